// File: rtl/nor_cmd_seq_if.sv
// Wishbone pipelined bus between the NOR command sequencer (master) and the
// parallel NOR bus block (slave).
interface nor_cmd_seq_if #(
  parameter int ADDRBITS = 26,
  parameter int DATABITS = 16
);
  logic [ADDRBITS-1:0] wb_adr_o;
  logic [DATABITS-1:0] wb_dat_o;
  logic                wb_we_o;
  logic                wb_stb_o;
  logic                wb_cyc_o;
  logic [DATABITS-1:0] wb_dat_i;
  logic                wb_ack_i;
  logic                wb_stall_i;
  logic                wb_err_i;

  modport master (
    output wb_adr_o, wb_dat_o, wb_we_o, wb_stb_o, wb_cyc_o,
    input  wb_dat_i, wb_ack_i, wb_stall_i, wb_err_i
  );

  modport slave (
    input  wb_adr_o, wb_dat_o, wb_we_o, wb_stb_o, wb_cyc_o,
    output wb_dat_i, wb_ack_i, wb_stall_i, wb_err_i
  );
endinterface

// File: rtl/nor_cmd_seq.sv
// Turns READ/PROGRAM/SECTOR_ERASE/RESET commands into JEDEC x16 wishbone write
// sequences, polls DQ6/DQ5 for completion and returns one status response.
module nor_cmd_seq #(
  parameter int                  ADDRBITS = 26,
  parameter int                  DATABITS = 16,
  parameter int                  POLLBITS = 16,
  parameter logic [POLLBITS-1:0] POLL_MAX = '1
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_ni,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic [1:0]          cmd_op_i,
  input  logic [ADDRBITS-1:0] cmd_addr_i,
  input  logic [DATABITS-1:0] cmd_data_i,
  output logic                rsp_valid_o,
  output logic [DATABITS-1:0] rsp_data_o,
  output logic [1:0]          rsp_status_o,
  nor_cmd_seq_if.master       wb
);

  typedef enum logic [2:0] {S_IDLE, S_BUS_REQ, S_BUS_WAIT, S_BUS_GAP, S_RESP} state_e;
  typedef enum logic [1:0] {PH_SEQ, PH_POLL, PH_RECOV} phase_e;

  typedef struct packed {
    logic [ADDRBITS-1:0] adr;
    logic [DATABITS-1:0] dat;
    logic                we;
    logic                last;
  } xfer_t;

  localparam logic [1:0] OP_READ  = 2'd0;
  localparam logic [1:0] OP_PROG  = 2'd1;
  localparam logic [1:0] OP_ERASE = 2'd2;
  localparam logic [1:0] OP_RESET = 2'd3;

  localparam logic [ADDRBITS-1:0] ADR_555 = ADDRBITS'(12'h555);
  localparam logic [ADDRBITS-1:0] ADR_2AA = ADDRBITS'(12'h2AA);
  localparam logic [ADDRBITS-1:0] ADR_000 = '0;
  localparam logic [DATABITS-1:0] D_AA = DATABITS'(8'hAA);
  localparam logic [DATABITS-1:0] D_55 = DATABITS'(8'h55);
  localparam logic [DATABITS-1:0] D_A0 = DATABITS'(8'hA0);
  localparam logic [DATABITS-1:0] D_80 = DATABITS'(8'h80);
  localparam logic [DATABITS-1:0] D_30 = DATABITS'(8'h30);
  localparam logic [DATABITS-1:0] D_F0 = DATABITS'(8'hF0);

  // Command table: one bus transfer per (opcode, step); 'last' ends the write phase.
  function automatic xfer_t seq_entry(input logic [1:0] op, input logic [2:0] step,
                                      input logic [ADDRBITS-1:0] addr,
                                      input logic [DATABITS-1:0] data);
    xfer_t x;
    x.adr  = ADR_555;
    x.dat  = D_AA;
    x.we   = 1'b1;
    x.last = 1'b0;
    case (op)
      OP_READ: begin
        x.adr  = addr;
        x.dat  = '0;
        x.we   = 1'b0;
        x.last = 1'b1;
      end
      OP_PROG: begin
        case (step)
          3'd0:    begin x.adr = ADR_555; x.dat = D_AA; end
          3'd1:    begin x.adr = ADR_2AA; x.dat = D_55; end
          3'd2:    begin x.adr = ADR_555; x.dat = D_A0; end
          default: begin x.adr = addr;    x.dat = data; x.last = 1'b1; end
        endcase
      end
      OP_ERASE: begin
        case (step)
          3'd0:    begin x.adr = ADR_555; x.dat = D_AA; end
          3'd1:    begin x.adr = ADR_2AA; x.dat = D_55; end
          3'd2:    begin x.adr = ADR_555; x.dat = D_80; end
          3'd3:    begin x.adr = ADR_555; x.dat = D_AA; end
          3'd4:    begin x.adr = ADR_2AA; x.dat = D_55; end
          default: begin x.adr = addr;    x.dat = D_30; x.last = 1'b1; end
        endcase
      end
      default: begin
        x.adr  = ADR_000;
        x.dat  = D_F0;
        x.last = 1'b1;
      end
    endcase
    return x;
  endfunction

  state_e              state_q, state_d;
  phase_e              phase_q, phase_d;
  logic [1:0]          op_q, op_d;
  logic [ADDRBITS-1:0] addr_q, addr_d;
  logic [DATABITS-1:0] data_q, data_d;
  logic [2:0]          step_q, step_d;
  logic [POLLBITS-1:0] poll_cnt_q, poll_cnt_d;
  logic [DATABITS-1:0] prev_q, prev_d;
  logic                have_prev_q, have_prev_d;
  logic                done_q, done_d;
  logic [DATABITS-1:0] res_data_q, res_data_d;
  logic [1:0]          res_status_q, res_status_d;
  logic [ADDRBITS-1:0] adr_q, adr_d;
  logic [DATABITS-1:0] dat_q, dat_d;
  logic                we_q, we_d;
  logic                cyc_q, cyc_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATABITS-1:0] rsp_data_q, rsp_data_d;
  logic [1:0]          rsp_status_q, rsp_status_d;

  xfer_t               first_entry, cur_entry, next_entry;
  logic [DATABITS-1:0] cur_rd;
  logic [POLLBITS-1:0] poll_inc;

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    op_d         = op_q;
    addr_d       = addr_q;
    data_d       = data_q;
    step_d       = step_q;
    poll_cnt_d   = poll_cnt_q;
    prev_d       = prev_q;
    have_prev_d  = have_prev_q;
    done_d       = done_q;
    res_data_d   = res_data_q;
    res_status_d = res_status_q;
    adr_d        = adr_q;
    dat_d        = dat_q;
    we_d         = we_q;
    cyc_d        = cyc_q;
    cmd_ready_d  = cmd_ready_q;
    rsp_valid_d  = 1'b0;
    rsp_data_d   = rsp_data_q;
    rsp_status_d = rsp_status_q;

    first_entry = seq_entry(cmd_op_i, 3'd0, cmd_addr_i, cmd_data_i);
    cur_entry   = seq_entry(op_q, step_q, addr_q, data_q);
    next_entry  = seq_entry(op_q, step_q + 3'd1, addr_q, data_q);
    cur_rd      = wb.wb_dat_i;
    poll_inc    = poll_cnt_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i && cmd_ready_q) begin
          op_d        = cmd_op_i;
          addr_d      = cmd_addr_i;
          data_d      = cmd_data_i;
          step_d      = 3'd0;
          phase_d     = PH_SEQ;
          adr_d       = first_entry.adr;
          dat_d       = first_entry.dat;
          we_d        = first_entry.we;
          cyc_d       = 1'b1;
          cmd_ready_d = 1'b0;
          state_d     = S_BUS_REQ;
        end
      end
      S_BUS_REQ: begin
        if (!wb.wb_stall_i) state_d = S_BUS_WAIT;
      end
      S_BUS_WAIT: begin
        // err wins over a coincident ack and skips any recovery write
        if (wb.wb_err_i) begin
          cyc_d        = 1'b0;
          state_d      = S_BUS_GAP;
          done_d       = 1'b1;
          res_data_d   = '0;
          res_status_d = 2'd3;
        end else if (wb.wb_ack_i) begin
          cyc_d   = 1'b0;
          state_d = S_BUS_GAP;
          case (phase_q)
            PH_SEQ: begin
              if (!cur_entry.last) begin
                step_d = step_q + 3'd1;
                adr_d  = next_entry.adr;
                dat_d  = next_entry.dat;
                we_d   = next_entry.we;
              end else if (op_q == OP_READ) begin
                done_d       = 1'b1;
                res_data_d   = cur_rd;
                res_status_d = 2'd0;
              end else if (op_q == OP_RESET) begin
                done_d       = 1'b1;
                res_data_d   = '0;
                res_status_d = 2'd0;
              end else begin
                phase_d     = PH_POLL;
                adr_d       = addr_q;
                we_d        = 1'b0;
                poll_cnt_d  = '0;
                have_prev_d = 1'b0;
              end
            end
            PH_POLL: begin
              res_data_d = cur_rd;
              if (!have_prev_q) begin
                prev_d      = cur_rd;
                have_prev_d = 1'b1;
              end else if (cur_rd[6] == prev_q[6]) begin
                done_d       = 1'b1;
                res_status_d = 2'd0;
              end else if (cur_rd[5] || (poll_inc == POLL_MAX)) begin
                phase_d      = PH_RECOV;
                res_status_d = cur_rd[5] ? 2'd1 : 2'd2;
                adr_d        = ADR_000;
                dat_d        = D_F0;
                we_d         = 1'b1;
              end else begin
                poll_cnt_d = poll_inc;
                prev_d     = cur_rd;
              end
            end
            default: done_d = 1'b1;
          endcase
        end
      end
      S_BUS_GAP: begin
        if (done_q) begin
          done_d       = 1'b0;
          rsp_valid_d  = 1'b1;
          rsp_data_d   = res_data_q;
          rsp_status_d = res_status_q;
          state_d      = S_RESP;
        end else begin
          cyc_d   = 1'b1;
          state_d = S_BUS_REQ;
        end
      end
      S_RESP: begin
        cmd_ready_d = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state_q      <= S_IDLE;
      phase_q      <= PH_SEQ;
      op_q         <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      step_q       <= '0;
      poll_cnt_q   <= '0;
      prev_q       <= '0;
      have_prev_q  <= 1'b0;
      done_q       <= 1'b0;
      res_data_q   <= '0;
      res_status_q <= '0;
      adr_q        <= '0;
      dat_q        <= '0;
      we_q         <= 1'b0;
      cyc_q        <= 1'b0;
      cmd_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_status_q <= '0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      op_q         <= op_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      step_q       <= step_d;
      poll_cnt_q   <= poll_cnt_d;
      prev_q       <= prev_d;
      have_prev_q  <= have_prev_d;
      done_q       <= done_d;
      res_data_q   <= res_data_d;
      res_status_q <= res_status_d;
      adr_q        <= adr_d;
      dat_q        <= dat_d;
      we_q         <= we_d;
      cyc_q        <= cyc_d;
      cmd_ready_q  <= cmd_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_status_q <= rsp_status_d;
    end
  end

  // stb is gated by the live stall input so a request is never offered while stalled
  assign wb.wb_stb_o  = (state_q == S_BUS_REQ) && !wb.wb_stall_i;
  assign wb.wb_cyc_o  = cyc_q;
  assign wb.wb_adr_o  = adr_q;
  assign wb.wb_dat_o  = dat_q;
  assign wb.wb_we_o   = we_q;
  assign cmd_ready_o  = cmd_ready_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_data_o   = rsp_data_q;
  assign rsp_status_o = rsp_status_q;

endmodule

// File: tb/tb_nor_cmd_seq.sv
// Scoreboard bench for nor_cmd_seq: a command-level reference model queues the
// expected bus transfers and responses; a monitor compares what the DUT presents.
module tb_nor_cmd_seq;
  localparam int AB = 26;
  localparam int DB = 16;
  localparam int PB = 16;
  localparam logic [PB-1:0] PMAX = 16'd4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = 2'd0;
  logic [AB-1:0] cmd_addr = '0;
  logic [DB-1:0] cmd_data = '0;
  logic          rsp_valid;
  logic [DB-1:0] rsp_data;
  logic [1:0]    rsp_status;

  always #5 clk = ~clk;

  nor_cmd_seq_if #(.ADDRBITS(AB), .DATABITS(DB)) bus ();

  nor_cmd_seq #(.ADDRBITS(AB), .DATABITS(DB), .POLLBITS(PB), .POLL_MAX(PMAX)) dut (
    .wb_clk_i    (clk),
    .wb_rst_ni   (rst_n),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_op_i    (cmd_op),
    .cmd_addr_i  (cmd_addr),
    .cmd_data_i  (cmd_data),
    .rsp_valid_o (rsp_valid),
    .rsp_data_o  (rsp_data),
    .rsp_status_o(rsp_status),
    .wb          (bus)
  );

  typedef struct {logic [AB-1:0] adr; logic we; logic [DB-1:0] dat;} xfer_t;
  typedef struct {logic err; logic [DB-1:0] rdata;} slv_t;
  typedef struct {logic [DB-1:0] data; logic [1:0] status;} rsp_t;

  xfer_t         exp_xfer_q[$];
  slv_t          slv_q[$];
  rsp_t          exp_rsp_q[$];
  logic [DB-1:0] force_q[$];

  int checks = 0;
  int errors = 0;
  int fixed_lat = 0;
  int err_at = -1;
  int xf_n = 0;
  int poll_mode = 0;
  int mon_reads = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit emit(input logic [AB-1:0] adr, input logic we,
                              input logic [DB-1:0] dat, input logic [DB-1:0] rdata);
    xfer_t x;
    slv_t  s;
    x.adr = adr; x.we = we; x.dat = dat;
    s.err = (xf_n == err_at);
    s.rdata = rdata;
    exp_xfer_q.push_back(x);
    slv_q.push_back(s);
    xf_n++;
    return s.err;
  endfunction

  function automatic logic [DB-1:0] gen_word(input logic [DB-1:0] prev, input bit first);
    logic [DB-1:0] w;
    if (force_q.size() > 0) return force_q.pop_front();
    w = 16'($urandom);
    if (first || poll_mode == 0) return w;
    if (poll_mode == 2 && $urandom_range(0, 3) == 0) return w;
    w[6] = ~prev[6];
    w[5] = 1'b0;
    return w;
  endfunction

  function automatic void push_rsp(input logic [DB-1:0] d, input logic [1:0] s);
    rsp_t r;
    r.data = d; r.status = s;
    exp_rsp_q.push_back(r);
  endfunction

  task automatic model_cmd(input logic [1:0] op, input logic [AB-1:0] addr, input logic [DB-1:0] data);
    logic [AB-1:0] wa[$];
    logic [DB-1:0] wd[$];
    logic [DB-1:0] cur, prev;
    logic [1:0]    st;
    int            cnt;
    xf_n = 0;
    if (op == 2'd1) begin
      wa.push_back(26'h555); wd.push_back(16'h00AA);
      wa.push_back(26'h2AA); wd.push_back(16'h0055);
      wa.push_back(26'h555); wd.push_back(16'h00A0);
      wa.push_back(addr);    wd.push_back(data);
    end else if (op == 2'd2) begin
      wa.push_back(26'h555); wd.push_back(16'h00AA);
      wa.push_back(26'h2AA); wd.push_back(16'h0055);
      wa.push_back(26'h555); wd.push_back(16'h0080);
      wa.push_back(26'h555); wd.push_back(16'h00AA);
      wa.push_back(26'h2AA); wd.push_back(16'h0055);
      wa.push_back(addr);    wd.push_back(16'h0030);
    end else if (op == 2'd3) begin
      wa.push_back(26'h000); wd.push_back(16'h00F0);
    end
    for (int i = 0; i < wa.size(); i++) begin
      if (emit(wa[i], 1'b1, wd[i], 16'h0)) begin push_rsp(16'h0, 2'd3); return; end
    end
    if (op == 2'd3) begin push_rsp(16'h0, 2'd0); return; end
    if (op == 2'd0) begin
      cur = gen_word(16'h0, 1'b1);
      if (emit(addr, 1'b0, 16'h0, cur)) push_rsp(16'h0, 2'd3);
      else push_rsp(cur, 2'd0);
      return;
    end
    prev = gen_word(16'h0, 1'b1);
    if (emit(addr, 1'b0, 16'h0, prev)) begin push_rsp(16'h0, 2'd3); return; end
    cnt = 0;
    st  = 2'd0;
    cur = prev;
    while (1) begin
      cur = gen_word(prev, 1'b0);
      if (emit(addr, 1'b0, 16'h0, cur)) begin push_rsp(16'h0, 2'd3); return; end
      if (cur[6] == prev[6]) begin push_rsp(cur, 2'd0); return; end
      if (cur[5]) begin st = 2'd1; break; end
      cnt++;
      if (cnt == int'(PMAX)) begin st = 2'd2; break; end
      prev = cur;
    end
    if (emit(26'h000, 1'b1, 16'h00F0, 16'h0)) begin push_rsp(16'h0, 2'd3); return; end
    push_rsp(cur, st);
  endtask

  // ---------------- wishbone slave ----------------
  initial begin
    int   lat = 0;
    bit   busy = 0;
    int   stall_left = 0;
    slv_t cs;
    cs.err = 1'b0; cs.rdata = '0;
    bus.wb_ack_i = 1'b0; bus.wb_err_i = 1'b0; bus.wb_stall_i = 1'b0; bus.wb_dat_i = '0;
    forever begin
      @(negedge clk);
      bus.wb_ack_i = 1'b0;
      bus.wb_err_i = 1'b0;
      bus.wb_dat_i = 16'($urandom);
      if (!rst_n) begin
        busy = 0; stall_left = 0; bus.wb_stall_i = 1'b0;
        continue;
      end
      if (busy) begin
        lat--;
        if (lat == 0) begin
          busy = 0;
          if (cs.err) bus.wb_err_i = 1'b1;
          else begin bus.wb_ack_i = 1'b1; bus.wb_dat_i = cs.rdata; end
          if ($urandom_range(0, 9) == 0) bus.wb_ack_i = 1'b1;
        end
      end
      if (stall_left > 0) begin
        bus.wb_stall_i = 1'b1; stall_left--;
      end else begin
        bus.wb_stall_i = 1'b0;
        if ($urandom_range(0, 7) == 0) stall_left = $urandom_range(1, 6);
      end
      #1;
      if (bus.wb_stb_o) begin
        if (slv_q.size() > 0) cs = slv_q.pop_front();
        else begin cs.err = 1'b0; cs.rdata = 16'hDEAD; end
        busy = 1;
        lat = (fixed_lat > 0) ? fixed_lat : $urandom_range(1, 4);
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    bit            prev_stb = 0;
    bit            prev_end = 0;
    logic          exp_ready = 1'b1;
    logic [DB-1:0] hold_d = '0;
    logic [1:0]    hold_s = '0;
    xfer_t         x;
    rsp_t          r;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        prev_stb = 0; prev_end = 0; exp_ready = 1'b1; hold_d = '0; hold_s = '0;
        continue;
      end
      chk("cmd_ready", 64'(cmd_ready), 64'(exp_ready));
      if (prev_end) chk("gap_cyc", 64'(bus.wb_cyc_o), 64'(0));
      if (bus.wb_stall_i && bus.wb_cyc_o) chk("stb_stalled", 64'(bus.wb_stb_o), 64'(0));
      if (bus.wb_stb_o) begin
        chk("stb_single", 64'(prev_stb), 64'(0));
        chk("stb_cyc", 64'(bus.wb_cyc_o), 64'(1));
        if (exp_xfer_q.size() == 0) begin
          chk("unexpected_xfer_adr", 64'(bus.wb_adr_o), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          x = exp_xfer_q.pop_front();
          chk("xfer_adr", 64'(bus.wb_adr_o), 64'(x.adr));
          chk("xfer_we", 64'(bus.wb_we_o), 64'(x.we));
          if (x.we) chk("xfer_dat", 64'(bus.wb_dat_o), 64'(x.dat));
          else mon_reads++;
        end
      end
      if (rsp_valid) begin
        if (exp_rsp_q.size() == 0) begin
          chk("unexpected_rsp", 64'(rsp_valid), 64'(0));
        end else begin
          r = exp_rsp_q.pop_front();
          chk("rsp_data", 64'(rsp_data), 64'(r.data));
          chk("rsp_status", 64'(rsp_status), 64'(r.status));
          $display("rsp data=%h status=%0d (expected %h/%0d)", rsp_data, rsp_status, r.data, r.status);
          hold_d = r.data; hold_s = r.status;
        end
      end else begin
        chk("rsp_hold", 64'({rsp_data, rsp_status}), 64'({hold_d, hold_s}));
      end
      prev_end = bus.wb_cyc_o && (bus.wb_ack_i || bus.wb_err_i);
      prev_stb = bus.wb_stb_o;
      if (cmd_valid && cmd_ready) exp_ready = 1'b0;
      if (rsp_valid) exp_ready = 1'b1;
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_ready();
    int guard = 0;
    @(negedge clk);
    while (!cmd_ready && guard < 200) begin @(negedge clk); guard++; end
    chk("ready_wait_timeout", 64'(cmd_ready), 64'(1));
  endtask

  task automatic issue(input logic [1:0] op, input logic [AB-1:0] addr, input logic [DB-1:0] data,
                       input int e_at, input int pmode, input int lat);
    int guard = 0;
    err_at = e_at; poll_mode = pmode; fixed_lat = lat;
    wait_ready();
    model_cmd(op, addr, data);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_data = data;
    @(negedge clk);
    while (1) begin
      if (rsp_valid) begin cmd_valid = 1'b0; break; end
      if (guard >= 3000) begin
        cmd_valid = 1'b0;
        chk("rsp_timeout", 64'(rsp_valid), 64'(1));
        return;
      end
      cmd_valid = ($urandom_range(0, 3) == 0);
      cmd_op    = 2'($urandom);
      cmd_addr  = 26'($urandom);
      cmd_data  = 16'($urandom);
      @(negedge clk);
      guard++;
    end
    checks++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int guard;
    int base;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    chk("reset_outputs",
        64'({bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.wb_adr_o, bus.wb_dat_o, rsp_valid, rsp_data, rsp_status, cmd_ready}),
        64'(1));
    @(negedge clk);
    rst_n = 1'b1;

    force_q.push_back(16'hBEEF);
    issue(2'd0, 26'h0001234, 16'h0, -1, 0, 10);
    force_q.push_back(16'h0040); force_q.push_back(16'h0000); force_q.push_back(16'h0000);
    issue(2'd1, 26'h100, 16'h5A5A, -1, 0, 0);
    force_q.push_back(16'h0040); force_q.push_back(16'h0020);
    issue(2'd2, 26'h20000, 16'h0, -1, 0, 0);
    issue(2'd1, 26'h3FF, 16'h1234, -1, 1, 0);
    issue(2'd3, 26'h0, 16'h0, -1, 0, 0);
    issue(2'd1, 26'h55, 16'hCAFE, 1, 0, 0);

    for (int n = 0; n < 60; n++) begin
      issue(2'($urandom), 26'($urandom), 16'($urandom),
            ($urandom_range(0, 7) == 0) ? $urandom_range(0, 9) : -1,
            $urandom_range(0, 2), 0);
    end

    // reset in the middle of a poll loop
    err_at = -1; poll_mode = 1; fixed_lat = 0;
    wait_ready();
    model_cmd(2'd1, 26'h777, 16'h1111);
    cmd_valid = 1'b1; cmd_op = 2'd1; cmd_addr = 26'h777; cmd_data = 16'h1111;
    @(negedge clk);
    cmd_valid = 1'b0;
    base = mon_reads;
    guard = 0;
    while (mon_reads < base + 2 && guard < 500) begin @(negedge clk); guard++; end
    chk("poll_reached", 64'(mon_reads >= base + 2), 64'(1));
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midreset_cyc", 64'(bus.wb_cyc_o), 64'(0));
    chk("midreset_outputs",
        64'({bus.wb_stb_o, bus.wb_we_o, rsp_valid, rsp_data, rsp_status, cmd_ready}), 64'(1));
    exp_xfer_q.delete(); slv_q.delete(); exp_rsp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    issue(2'd0, 26'h0ABCDE, 16'h0, -1, 0, 0);

    repeat (10) @(negedge clk);
    chk("leftover_xfers", 64'(exp_xfer_q.size()), 64'(0));
    chk("leftover_rsps", 64'(exp_rsp_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
